// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states plus timing and parity helpers,
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic int cycles_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Words narrower than 64 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [63:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts CPB clock cycles per bit and strobes bit_end on the last one.
// Holding clear parks the counter at zero so the next bit starts full length.
module uart_bit_timer #(
  parameter int CPB = 16
) (
  input  logic tick,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  logic [CNT_W-1:0] count;

  assign bit_end = !clear && (count == CNT_W'(CPB - 1));

  always_ff @(posedge tick or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, M stop bits.
// All frame outputs are registered so tx only moves on bit boundaries.
module uart_tx
  import uart_pkg::*;
#(
  parameter int N          = 8,
  parameter int M          = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int BAUD_RATE  = 9600,
  parameter int CLK_FREQ   = 50000000
) (
  input  logic         tick,
  input  logic         reset,
  input  logic         tx_start,
  input  logic [N-1:0] data_in,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int CPB    = cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int MAX_NM = (N > M) ? N : M;
  localparam int IDX_W  = $clog2(MAX_NM + 1);

  state_t           state_q, state_d;
  logic [N-1:0]     shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             parity_q, parity_d;
  logic             tx_d, busy_d, done_d;
  logic             bit_end;

  uart_bit_timer #(.CPB(CPB)) u_timer (
    .tick    (tick),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .bit_end (bit_end)
  );

  always_ff @(posedge tick or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // The idx counter is reused: data bits in DATA, stop bits in STOP.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    tx_d     = tx;
    busy_d   = busy;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          shift_d  = data_in;
          parity_d = parity_bit(64'(data_in), PARITY_ODD != 0);
          idx_d    = '0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(N - 1)) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(M - 1)) begin
            idx_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three framing variants share one stimulus
// stream, and a per-cycle monitor checks tx/busy/done against queued frames.
module tb_uart_tx;

  localparam int CPB  = 16;
  localparam int NDUT = 3;

  logic       tick     = 1'b0;
  logic       reset    = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] data_in  = 8'h00;

  logic [NDUT-1:0] tx_w, busy_w, done_w;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] data;
    int         e0;
  } frame_t;

  frame_t exp_q[NDUT][$];
  int     next_free[NDUT];
  bit     active[NDUT];
  frame_t cur[NDUT];

  always #5 tick = ~tick;

  // dut0: 8N1, dut1: 8E2, dut2: 8O1
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_tx #(
      .N          (8),
      .M          ((g == 1) ? 2 : 1),
      .PARITY_EN  ((g == 0) ? 0 : 1),
      .PARITY_ODD ((g == 2) ? 1 : 0),
      .BAUD_RATE  (10),
      .CLK_FREQ   (160)
    ) dut (
      .tick     (tick),
      .reset    (reset),
      .tx_start (tx_start),
      .data_in  (data_in),
      .tx       (tx_w[g]),
      .busy     (busy_w[g]),
      .done     (done_w[g])
    );
  end

  function automatic int stop_bits(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int par_en(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int par_odd(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  function automatic int frame_len(input int i);
    return (1 + 8 + par_en(i) + stop_bits(i)) * CPB;
  endfunction

  // Bit b of the frame: 0 start, 1..8 data LSB first, then parity, then stops.
  function automatic logic exp_bit(input int i, input logic [7:0] d, input int b);
    int ones;
    if (b <= 0) return 1'b0;
    if (b <= 8) return d[b-1];
    ones = $countones(d);
    if (par_en(i) != 0 && b == 9) return ((ones % 2) == 1) ^ (par_odd(i) != 0);
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input int i, input logic [2:0] got,
                             input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s dut%0d cyc=%0d {tx,busy,done} got=%b exp=%b",
               name, i, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int hold, input int gap,
                               input bit scramble);
    @(negedge tick);
    data_in  = d;
    tx_start = 1'b1;
    repeat (hold) @(negedge tick);
    tx_start = 1'b0;
    repeat (gap) begin
      @(negedge tick);
      if (scramble) data_in = 8'($urandom);
    end
  endtask

  // Reference model at the edge, then the monitor 2 time units later.
  always @(posedge tick) begin
    frame_t      f;
    logic [2:0]  expv;
    int          off;
    cyc++;
    for (int i = 0; i < NDUT; i++) begin
      if (reset) begin
        exp_q[i].delete();
        next_free[i] = 0;
      end else if (tx_start && cyc >= next_free[i]) begin
        f.data = data_in;
        f.e0   = cyc;
        exp_q[i].push_back(f);
        next_free[i] = cyc + frame_len(i) + 1;
      end
    end
    #2;
    for (int i = 0; i < NDUT; i++) begin
      if (reset) begin
        active[i] = 1'b0;
        checkOutput("reset_idle", i, {tx_w[i], busy_w[i], done_w[i]}, 3'b100);
      end else begin
        if (!active[i] && busy_w[i]) begin
          total++;
          if (exp_q[i].size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_frame dut%0d cyc=%0d got=busy exp=idle", i, cyc);
          end else begin
            cur[i]    = exp_q[i].pop_front();
            active[i] = 1'b1;
            if (cur[i].e0 != cyc) begin
              bad++;
              $display("[TB] FAIL start_latency dut%0d got=%0d exp=%0d", i, cyc, cur[i].e0);
            end
          end
        end
        if (!active[i] && exp_q[i].size() > 0 && exp_q[i][0].e0 < cyc) begin
          total++;
          bad++;
          $display("[TB] FAIL missing_frame dut%0d cyc=%0d got=idle exp=frame from %0d",
                   i, cyc, exp_q[i][0].e0);
          void'(exp_q[i].pop_front());
        end
        expv = 3'b100;
        if (active[i]) begin
          off = cyc - cur[i].e0;
          if (off < 0) off = 0;
          if (off < frame_len(i)) begin
            expv = {exp_bit(i, cur[i].data, off / CPB), 2'b10};
          end else begin
            expv      = 3'b101;
            active[i] = 1'b0;
          end
        end
        checkOutput("frame", i, {tx_w[i], busy_w[i], done_w[i]}, expv);
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge tick);
    reset = 1'b0;
    repeat (100) @(negedge tick);

    applyStimulus(8'hA5, 1, 200, 1'b0);
    applyStimulus(8'h07, 1, 200, 1'b0);
    applyStimulus(8'h00, 1, 60, 1'b0);
    applyStimulus(8'hFF, 1, 200, 1'b0);
    applyStimulus(8'h3C, 700, 250, 1'b0);

    // Abort inside data bit 3 (a 0 bit for 8'hA5) to see tx jump high at once.
    applyStimulus(8'hA5, 1, 70, 1'b0);
    reset = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++)
      checkOutput("reset_async", i, {tx_w[i], busy_w[i], done_w[i]}, 3'b100);
    repeat (3) @(negedge tick);
    reset = 1'b0;
    applyStimulus(8'h81, 1, 200, 1'b0);

    for (int k = 0; k < 40; k++)
      applyStimulus(8'($urandom), $urandom_range(1, 3), $urandom_range(0, 220), 1'b1);

    repeat (250) @(negedge tick);
    for (int i = 0; i < NDUT; i++) begin
      total++;
      if (active[i] || exp_q[i].size() != 0) begin
        bad++;
        $display("[TB] FAIL leftover dut%0d got=%0d pending exp=0", i,
                 exp_q[i].size() + (active[i] ? 1 : 0));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
